// File: rtl/tpu_top.sv
// tpu_top: int8 matrix-multiply engine, C[m x n] = A[m x k] * B[k x n].
//   Three 32-bit global buffers (GBUFF_A, GBUFF_B inputs; GBUFF_OUT result),
//   a 4x4 output-stationary systolic MAC array and a tiling controller that
//   walks 4x4 output blocks (column tiles outer, row tiles inner).
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   start - level request, accepted in IDLE; must drop before a new run
//   m,k,n - problem dimensions, sampled when a run starts
//   done  - high from the cycle after the last C write until start drops

// tpu_gbuff: single-port-write / registered-read word buffer, contents not reset.
//   we/waddr/wdata - write port; raddr/rdata - one-cycle synchronous read.
module tpu_gbuff #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned AW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] gbuff [DEPTH];

    always_ff @(posedge clk) begin
        if (we) gbuff[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata <= '0;
        else      rdata <= gbuff[raddr];
    end
endmodule

module tpu_top #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned ARRAY_N     = 4,
    parameter int unsigned GBUFF_DEPTH = 256,
    parameter int unsigned GBUFF_AW    = 8,
    parameter int unsigned ACC_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] m,
    input  logic [3:0] k,
    input  logic [3:0] n,
    output logic       done
);
    localparam int unsigned SKEW = ARRAY_N - 1;
    localparam int unsigned PW   = 2 * DATA_W;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t      state;
    logic [3:0]  m_r, k_r, n_r;
    logic [1:0]  rt, ct, wr_row;
    logic [4:0]  cnt;
    logic        rd_valid;
    logic [4:0]  r_tiles, c_tiles;
    logic [3:0]  c_row;
    logic        acc_clr;

    logic [GBUFF_AW-1:0] a_raddr, b_raddr, c_waddr;
    logic [WORD_W-1:0]   a_rdata, b_rdata, c_wdata, unused_c_rdata;
    logic                c_we;

    logic [DATA_W-1:0] a_lane [ARRAY_N];
    logic [DATA_W-1:0] b_lane [ARRAY_N];
    logic [DATA_W-1:0] a_sh   [ARRAY_N][SKEW];
    logic [DATA_W-1:0] b_sh   [ARRAY_N][SKEW];
    logic [DATA_W-1:0] a_in   [ARRAY_N][ARRAY_N];
    logic [DATA_W-1:0] b_in   [ARRAY_N][ARRAY_N];
    logic [DATA_W-1:0] a_pe   [ARRAY_N][ARRAY_N];
    logic [DATA_W-1:0] b_pe   [ARRAY_N][ARRAY_N];
    logic signed [PW-1:0] prod [ARRAY_N][ARRAY_N];
    logic [ACC_W-1:0]  acc    [ARRAY_N][ARRAY_N];

    tpu_gbuff #(.WORD_W(WORD_W), .DEPTH(GBUFF_DEPTH), .AW(GBUFF_AW)) GBUFF_A (
        .clk(clk), .rst(rst), .we(1'b0), .waddr('0), .wdata('0),
        .raddr(a_raddr), .rdata(a_rdata)
    );
    tpu_gbuff #(.WORD_W(WORD_W), .DEPTH(GBUFF_DEPTH), .AW(GBUFF_AW)) GBUFF_B (
        .clk(clk), .rst(rst), .we(1'b0), .waddr('0), .wdata('0),
        .raddr(b_raddr), .rdata(b_rdata)
    );
    tpu_gbuff #(.WORD_W(WORD_W), .DEPTH(GBUFF_DEPTH), .AW(GBUFF_AW)) GBUFF_OUT (
        .clk(clk), .rst(rst), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
        .raddr('0), .rdata(unused_c_rdata)
    );

    always_comb begin
        r_tiles = (5'(m_r) + 5'(ARRAY_N - 1)) / 5'(ARRAY_N);
        c_tiles = (5'(n_r) + 5'(ARRAY_N - 1)) / 5'(ARRAY_N);
        c_row   = {rt, wr_row};
        a_raddr = GBUFF_AW'(rt) * GBUFF_AW'(k_r) + GBUFF_AW'(cnt);
        b_raddr = GBUFF_AW'(ct) * GBUFF_AW'(k_r) + GBUFF_AW'(cnt);
        c_waddr = GBUFF_AW'(c_row) * GBUFF_AW'(c_tiles) + GBUFF_AW'(ct);
        c_we    = (state == S_WRITE) && (c_row < m_r);
        acc_clr = (state == S_LOAD) && (cnt == '0);
        c_wdata = '0;
        for (int unsigned j = 0; j < ARRAY_N; j++) begin
            if ({ct, 2'(j)} < n_r)
                c_wdata[DATA_W*j +: DATA_W] = acc[wr_row][j][DATA_W-1:0];
        end
    end

    // Lanes are zeroed outside the read window so no stale buffer data
    // reaches the array between tiles.
    always_comb begin
        for (int unsigned i = 0; i < ARRAY_N; i++) begin
            a_lane[i] = rd_valid ? a_rdata[DATA_W*i +: DATA_W] : '0;
            b_lane[i] = rd_valid ? b_rdata[DATA_W*i +: DATA_W] : '0;
        end
        a_in[0][0] = a_lane[0];
        b_in[0][0] = b_lane[0];
        for (int unsigned i = 1; i < ARRAY_N; i++) begin
            a_in[i][0] = a_sh[i][i-1];
            b_in[0][i] = b_sh[i][i-1];
        end
        for (int unsigned i = 0; i < ARRAY_N; i++) begin
            for (int unsigned j = 1; j < ARRAY_N; j++) begin
                a_in[i][j] = a_pe[i][j-1];
                b_in[j][i] = b_pe[j-1][i];
            end
        end
        for (int unsigned i = 0; i < ARRAY_N; i++) begin
            for (int unsigned j = 0; j < ARRAY_N; j++) begin
                prod[i][j] = $signed({{DATA_W{a_in[i][j][DATA_W-1]}}, a_in[i][j]}) *
                             $signed({{DATA_W{b_in[i][j][DATA_W-1]}}, b_in[i][j]});
            end
        end
    end

    // Row i of A / column j of B enter the array i / j cycles late.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ARRAY_N; i++) begin
                for (int unsigned d = 0; d < SKEW; d++) begin
                    a_sh[i][d] <= '0;
                    b_sh[i][d] <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < ARRAY_N; i++) begin
                a_sh[i][0] <= a_lane[i];
                b_sh[i][0] <= b_lane[i];
                for (int unsigned d = 1; d < SKEW; d++) begin
                    a_sh[i][d] <= a_sh[i][d-1];
                    b_sh[i][d] <= b_sh[i][d-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < ARRAY_N; i++) begin
                for (int unsigned j = 0; j < ARRAY_N; j++) begin
                    a_pe[i][j] <= '0;
                    b_pe[i][j] <= '0;
                    acc[i][j]  <= '0;
                end
            end
        end else begin
            for (int unsigned i = 0; i < ARRAY_N; i++) begin
                for (int unsigned j = 0; j < ARRAY_N; j++) begin
                    a_pe[i][j] <= a_in[i][j];
                    b_pe[i][j] <= b_in[i][j];
                    if (acc_clr) acc[i][j] <= '0;
                    else acc[i][j] <= acc[i][j] + {{(ACC_W-PW){prod[i][j][PW-1]}}, prod[i][j]};
                end
            end
        end
    end

    // cnt runs continuously through LOAD and DRAIN: reads at 0..k-1, the last
    // product lands in PE(3,3) at k+2*SKEW, so WRITE starts at k+2*SKEW+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            m_r      <= '0;
            k_r      <= '0;
            n_r      <= '0;
            rt       <= '0;
            ct       <= '0;
            wr_row   <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= (state == S_LOAD) && (cnt < 5'(k_r));
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_r   <= m;
                        k_r   <= k;
                        n_r   <= n;
                        rt    <= '0;
                        ct    <= '0;
                        cnt   <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(k_r) + 5'(SKEW) - 5'd1) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(k_r) + 5'(2 * SKEW)) begin
                        wr_row <= '0;
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    wr_row <= wr_row + 2'd1;
                    if (wr_row == 2'(ARRAY_N - 1)) begin
                        cnt   <= '0;
                        state <= S_LOAD;
                        if (rt == r_tiles[1:0] - 2'd1) begin
                            rt <= '0;
                            if (ct == c_tiles[1:0] - 2'd1) begin
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                ct <= ct + 2'd1;
                            end
                        end else begin
                            rt <= rt + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tpu_top.sv
// tb_tpu_top: self-checking bench for tpu_top. Matrices live in plain int
// arrays; expected C words come from direct dot products over those arrays.
module tb_tpu_top;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] m = '0, k = '0, n = '0;
    logic       done;

    int checks = 0;
    int errors = 0;
    int a_mat [15][15];
    int b_mat [15][15];

    tpu_top dut (.clk(clk), .rst(rst), .start(start), .m(m), .k(k), .n(n), .done(done));

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_word(int r, int ct, int mm, int kk, int nn);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            int col;
            int s;
            col = 4 * ct + j;
            s = 0;
            if (r < mm && col < nn) begin
                for (int x = 0; x < kk; x++) s += a_mat[r][x] * b_mat[x][col];
                w[8*j +: 8] = 8'(s);
            end
        end
        return w;
    endfunction

    task automatic load_bufs(int mm, int kk, int nn);
        logic [31:0] w;
        for (int t = 0; t < (mm + 3) / 4; t++) begin
            for (int x = 0; x < kk; x++) begin
                w = '0;
                for (int j = 0; j < 4; j++)
                    if (4 * t + j < mm) w[8*j +: 8] = 8'(a_mat[4*t+j][x]);
                dut.GBUFF_A.gbuff[t*kk+x] = w;
            end
        end
        for (int t = 0; t < (nn + 3) / 4; t++) begin
            for (int x = 0; x < kk; x++) begin
                w = '0;
                for (int j = 0; j < 4; j++)
                    if (4 * t + j < nn) w[8*j +: 8] = 8'(b_mat[x][4*t+j]);
                dut.GBUFF_B.gbuff[t*kk+x] = w;
            end
        end
    endtask

    task automatic set_identity();
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15; j++) begin
                a_mat[i][j] = (i == j) ? 1 : 0;
                b_mat[i][j] = (i < 4 && j < 4) ? 4 * i + j + 1 : 0;
            end
    endtask

    task automatic set_random();
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15; j++) begin
                a_mat[i][j] = int'($urandom_range(0, 255)) - 128;
                b_mat[i][j] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    // Raises start and waits (bounded) for done; start is left high.
    task automatic run_op(string tag, int mm, int kk, int nn, int budget);
        bit ok;
        int c;
        @(negedge clk);
        m = 4'(mm); k = 4'(kk); n = 4'(nn);
        start = 1'b1;
        ok = 1'b0;
        for (c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s completion: done=%b after %0d cycles, required 1", tag, done, c);
        end
    endtask

    task automatic end_op();
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset done: got %b, required 0", done);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL idle after reset done: got %b, required 0", done);
        end
    endtask

    task automatic test_identity();
        logic [31:0] got, exp;
        set_identity();
        load_bufs(4, 4, 4);
        run_op("identity", 4, 4, 4, 300);
        for (int r = 0; r < 4; r++) begin
            got = dut.GBUFF_OUT.gbuff[r];
            exp = ref_word(r, 0, 4, 4, 4);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL identity C word %0d: got %h, required %h", r, got, exp);
            end
        end
        got = dut.GBUFF_OUT.gbuff[0];
        checks++;
        if (got !== 32'h04030201) begin
            errors++;
            $display("FAIL identity lane order: got %h, required 04030201", got);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL identity done hold: got %b, required 1", done);
        end
        end_op();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL identity done clear: got %b, required 0", done);
        end
    endtask

    task automatic test_all_twos();
        logic [31:0] got;
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15; j++) begin
                a_mat[i][j] = 2;
                b_mat[i][j] = 2;
            end
        load_bufs(4, 4, 4);
        run_op("twos", 4, 4, 4, 300);
        for (int r = 0; r < 4; r++) begin
            got = dut.GBUFF_OUT.gbuff[r];
            checks++;
            if (got !== 32'h10101010) begin
                errors++;
                $display("FAIL twos C word %0d: got %h, required 10101010", r, got);
            end
        end
        end_op();
    endtask

    task automatic test_signed_wrap();
        logic [31:0] got;
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15; j++) begin
                a_mat[i][j] = 0;
                b_mat[i][j] = 0;
            end
        a_mat[0][0] = 127;
        a_mat[0][1] = -128;
        b_mat[0][0] = 2;
        b_mat[1][0] = 1;
        load_bufs(1, 2, 1);
        run_op("signed", 1, 2, 1, 300);
        got = dut.GBUFF_OUT.gbuff[0];
        checks++;
        if (got !== 32'h0000007E) begin
            errors++;
            $display("FAIL signed wrap C word 0: got %h, required 0000007e", got);
        end
        end_op();
    endtask

    task automatic test_random();
        int dims [4][3];
        logic [31:0] got, exp;
        dims[0] = '{6, 5, 9};
        for (int t = 1; t < 4; t++)
            dims[t] = '{int'($urandom_range(1, 15)), int'($urandom_range(1, 15)),
                        int'($urandom_range(1, 12))};
        for (int t = 0; t < 4; t++) begin
            int mm, kk, nn, cw;
            mm = dims[t][0]; kk = dims[t][1]; nn = dims[t][2];
            cw = (nn + 3) / 4;
            set_random();
            load_bufs(mm, kk, nn);
            run_op("random", mm, kk, nn, 2000);
            for (int r = 0; r < mm; r++)
                for (int c = 0; c < cw; c++) begin
                    got = dut.GBUFF_OUT.gbuff[r*cw+c];
                    exp = ref_word(r, c, mm, kk, nn);
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL random %0dx%0dx%0d C[%0d][%0d]: got %h, required %h",
                                 mm, kk, nn, r, c, got, exp);
                    end
                end
            end_op();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got, exp;
        for (int i = 0; i < 15; i++)
            for (int j = 0; j < 15; j++) begin
                a_mat[i][j] = 2;
                b_mat[i][j] = 2;
            end
        load_bufs(4, 4, 4);
        run_op("reset-done", 4, 4, 4, 300);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL async reset in DONE: done=%b, required 0", done);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        set_identity();
        load_bufs(4, 4, 4);
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL async reset in LOAD: done=%b, required 0", done);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL idle after mid reset: done=%b, required 0", done);
        end
        run_op("rerun", 4, 4, 4, 300);
        for (int r = 0; r < 4; r++) begin
            got = dut.GBUFF_OUT.gbuff[r];
            exp = ref_word(r, 0, 4, 4, 4);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rerun C word %0d: got %h, required %h", r, got, exp);
            end
        end
        end_op();
    endtask

    task automatic test_hold_start();
        logic [31:0] got, exp;
        bit dropped;
        set_random();
        load_bufs(15, 15, 12);
        run_op("large", 15, 15, 12, 2000);
        dropped = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped) begin
            errors++;
            $display("FAIL start held: done=%b after drop, required 1 throughout", done);
        end
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 3; c++) begin
                got = dut.GBUFF_OUT.gbuff[r*3+c];
                exp = ref_word(r, c, 15, 15, 12);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL large C[%0d][%0d]: got %h, required %h", r, c, got, exp);
                end
            end
        end_op();
    endtask

    initial begin
        test_reset();
        test_identity();
        test_all_twos();
        test_signed_wrap();
        test_random();
        test_reset_mid();
        test_hold_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
